// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC sine/cosine engine.
//   ATAN_Q30    : atan(2^-i), i = 0..31, Q2.30
//   K_Q30       : CORDIC gain compensation 0.6072529..., Q2.30
//   PI_Q29      : pi, Q3.29
//   HALF_PI_Q29 : pi/2, Q3.29
//   scale_q30() : re-scales a Q.30 constant to an arbitrary fraction width, rounding to nearest
//   state_t     : controller states
package cordic_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_DONE
    } state_t;

    localparam logic [31:0] ATAN_Q30 [32] = '{
        32'h3243F6A8, 32'h1DAC6705, 32'h0FADBAFC, 32'h07F56EA6,
        32'h03FEAB76, 32'h01FFD55B, 32'h00FFFAAA, 32'h007FFF55,
        32'h003FFFEA, 32'h001FFFFD, 32'h000FFFFF, 32'h0007FFFF,
        32'h0003FFFF, 32'h0001FFFF, 32'h0000FFFF, 32'h00007FFF,
        32'h00003FFF, 32'h00001FFF, 32'h00000FFF, 32'h000007FF,
        32'h000003FF, 32'h000001FF, 32'h000000FF, 32'h0000007F,
        32'h0000003F, 32'h0000001F, 32'h0000000F, 32'h00000008,
        32'h00000004, 32'h00000002, 32'h00000001, 32'h00000000
    };

    localparam logic [31:0] K_Q30       = 32'h26DD3B6A;
    localparam logic [31:0] PI_Q29      = 32'h6487ED51;
    localparam logic [31:0] HALF_PI_Q29 = 32'h3243F6A9;

    // Zero-extend a 32-bit table word to a signed 64-bit value.
    function automatic longint q30(input logic [31:0] v);
        return longint'({32'h0, v});
    endfunction

    // Re-scale a value with 30 fraction bits to 'frac' fraction bits (round to nearest).
    function automatic longint scale_q30(input longint c, input int unsigned frac);
        if (frac >= 30)
            return c <<< (frac - 30);
        return (c + (longint'(1) <<< (29 - frac))) >>> (30 - frac);
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational atan(2^-idx) lookup, scaled to the datapath format.
//   idx   : iteration index 0..31
//   value : atan(2^-idx), signed, OUT_W bits with OUT_FRAC fraction bits
module cordic_atan_rom #(
    parameter int OUT_W    = 19,
    parameter int OUT_FRAC = 12
) (
    input  logic [4:0]              idx,
    output logic signed [OUT_W-1:0] value
);
    import cordic_pkg::*;

    always_comb begin
        value = OUT_W'(scale_q30(q30(ATAN_Q30[idx]), OUT_FRAC));
    end

endmodule

// File: rtl/cordic_sincos.sv
// Iterative rotation-mode CORDIC computing cos(X) and sin(X) behind a start/done handshake.
// Optional full-circle range reduction is enabled by defining CORDIC_SINCOS_RANGE_EN;
// without it the angle is clamped to [-pi/2, +pi/2].
//   clk, rst : clock, synchronous active-high reset
//   start    : request, accepted in IDLE or DONE
//   X        : angle in radians, Q(WIDTH-FRAC).FRAC
//   done     : result valid (held)
//   busy     : computation in progress (PREP through last iteration)
//   CosX     : cos(X), same format as X
//   SinX     : sin(X), same format as X
module cordic_sincos #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 10,
    parameter int ITER  = 14,
    parameter int GUARD = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    output logic             done,
    output logic             busy,
    output logic [WIDTH-1:0] CosX,
    output logic [WIDTH-1:0] SinX
);
    import cordic_pkg::*;

    localparam int IW = WIDTH + GUARD + 1;
    localparam int IF = FRAC + GUARD;

    localparam logic signed [IW-1:0] K_I   = IW'(scale_q30(q30(K_Q30), IF));
    localparam logic signed [IW-1:0] PI_I  = IW'(scale_q30(q30(PI_Q29) <<< 1, IF));
    localparam logic signed [IW-1:0] HPI_I = IW'(scale_q30(q30(HALF_PI_Q29) <<< 1, IF));

    localparam logic signed [IW+1:0] RND  = (IW+2)'((2 ** GUARD) / 2);
    localparam logic signed [IW+1:0] MAXV = (IW+2)'((longint'(1) <<< (WIDTH - 1)) - 1);
    localparam logic signed [IW+1:0] MINV = -MAXV - 1;

    state_t                 state;
    logic signed [WIDTH-1:0] x_cap;
    logic signed [IW-1:0]   xr, yr, z;
    logic signed [IW-1:0]   x_ext, z_red, atan_i, x_sh, y_sh;
    logic                   neg, neg_red, d;
    logic [5:0]             i;

    assign x_ext = IW'(x_cap) <<< GUARD;

`ifdef CORDIC_SINCOS_RANGE_EN
    logic signed [IW-1:0] x_sat;

    // Saturate to [-pi, pi]; fold the outer quarters back by pi and negate at output.
    always_comb begin
        x_sat = x_ext;
        if (x_ext > PI_I)
            x_sat = PI_I;
        else if (x_ext < -PI_I)
            x_sat = -PI_I;
        z_red   = x_sat;
        neg_red = 1'b0;
        if (x_sat > HPI_I) begin
            z_red   = x_sat - PI_I;
            neg_red = 1'b1;
        end else if (x_sat < -HPI_I) begin
            z_red   = x_sat + PI_I;
            neg_red = 1'b1;
        end
    end
`else
    always_comb begin
        z_red   = x_ext;
        neg_red = 1'b0;
        if (x_ext > HPI_I)
            z_red = HPI_I;
        else if (x_ext < -HPI_I)
            z_red = -HPI_I;
    end
`endif

    cordic_atan_rom #(
        .OUT_W   (IW),
        .OUT_FRAC(IF)
    ) u_atan (
        .idx  (i[4:0]),
        .value(atan_i)
    );

    assign d    = ~z[IW-1];
    assign x_sh = xr >>> i;
    assign y_sh = yr >>> i;

    // Drop guard bits (round half up), apply fold negation, saturate to the output word.
    function automatic logic signed [WIDTH-1:0] finish_out(input logic signed [IW-1:0] v,
                                                           input logic n);
        logic signed [IW+1:0] t;
        t = ((IW+2)'(v) + RND) >>> GUARD;
        if (n)
            t = -t;
        if (t > MAXV)
            return MAXV[WIDTH-1:0];
        if (t < MINV)
            return MINV[WIDTH-1:0];
        return t[WIDTH-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
            CosX  <= '0;
            SinX  <= '0;
            i     <= '0;
            x_cap <= '0;
            xr    <= '0;
            yr    <= '0;
            z     <= '0;
            neg   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_cap <= X;
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_PREP;
                    end
                end
                S_PREP: begin
                    xr    <= K_I;
                    yr    <= '0;
                    z     <= z_red;
                    neg   <= neg_red;
                    i     <= '0;
                    state <= S_ITER;
                end
                S_ITER: begin
                    if (d) begin
                        xr <= xr - y_sh;
                        yr <= yr + x_sh;
                        z  <= z - atan_i;
                    end else begin
                        xr <= xr + y_sh;
                        yr <= yr - x_sh;
                        z  <= z + atan_i;
                    end
                    i <= i + 6'd1;
                    if (i == 6'(ITER - 1)) begin
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Results are registered once, on the first DONE cycle (done still low).
                    if (start) begin
                        x_cap <= X;
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_PREP;
                    end else if (!done) begin
                        CosX <= finish_out(xr, neg);
                        SinX <= finish_out(yr, neg);
                        done <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_sincos.sv
// Self-checking bench for cordic_sincos: a default 16-bit instance and a 24-bit sweep instance,
// both compared against real-valued sin/cos. Honours CORDIC_SINCOS_RANGE_EN when defined.
module tb_cordic_sincos;

    localparam real M_PI = 3.141592653589793;
`ifdef CORDIC_SINCOS_RANGE_EN
    localparam bit RANGE = 1'b1;
`else
    localparam bit RANGE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               start0 = 1'b0;
    logic [15:0]        X0 = '0;
    logic               done0, busy0;
    logic signed [15:0] cos0, sin0;

    logic               start1 = 1'b0;
    logic [23:0]        X1 = '0;
    logic               done1, busy1;
    logic signed [23:0] cos1, sin1;

    cordic_sincos dut0 (
        .clk(clk), .rst(rst), .start(start0), .X(X0),
        .done(done0), .busy(busy0), .CosX(cos0), .SinX(sin0)
    );

    cordic_sincos #(.WIDTH(24), .FRAC(20), .ITER(22), .GUARD(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .X(X1),
        .done(done1), .busy(busy1), .CosX(cos1), .SinX(sin1)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input longint got, input longint want,
                         input longint tol);
        n_vec++;
        assert (((got - want <= tol) && (want - got <= tol)) === 1'b1)
        else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d (tol %0d)", tag, got, want, tol);
        end
    endtask

    // Real-valued reference: clamp (or saturate to the full turn), then round cos/sin.
    task automatic ref_cs(input longint x, input int frac, input int width,
                          output longint ec, output longint es);
        real    sc, a, lim;
        longint hi;
        sc  = 2.0 ** frac;
        a   = real'(x) / sc;
        lim = RANGE ? M_PI : M_PI / 2.0;
        if (a > lim) a = lim;
        if (a < -lim) a = -lim;
        ec = longint'($floor($cos(a) * sc + 0.5));
        es = longint'($floor($sin(a) * sc + 0.5));
        hi = (longint'(1) <<< (width - 1)) - 1;
        if (ec > hi) ec = hi;
        if (es > hi) es = hi;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction on the 16-bit instance; optionally pulses start mid-computation.
    task automatic run0(input logic signed [15:0] x, input string tag, input bit pulse_mid);
        int     lat;
        bit     overlap;
        longint ec, es;
        X0 = x;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check({tag, "_done_clr"}, longint'(done0), 0, 0);
        check({tag, "_busy_set"}, longint'(busy0), 1, 0);
        lat = 0;
        overlap = 1'b0;
        while (!done0 && lat < 40) begin
            if (pulse_mid && lat == 5) begin
                X0 = ~x;
                start0 = 1'b1;
            end
            tick();
            start0 = 1'b0;
            lat++;
            if (busy0 && done0) overlap = 1'b1;
        end
        check({tag, "_latency"}, lat, 16, 0);
        check({tag, "_busy_done_excl"}, longint'(overlap), 0, 0);
        ref_cs(longint'(x), 10, 16, ec, es);
        check({tag, "_cos"}, longint'(cos0), ec, 2);
        check({tag, "_sin"}, longint'(sin0), es, 2);
    endtask

    task automatic run1(input logic signed [23:0] x, input string tag);
        int     lat;
        longint ec, es;
        X1 = x;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        lat = 0;
        while (!done1 && lat < 60) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 24, 0);
        ref_cs(longint'(x), 20, 24, ec, es);
        check({tag, "_cos"}, longint'(cos1), ec, 4);
        check({tag, "_sin"}, longint'(sin1), es, 4);
    endtask

    initial begin
        longint ec, es;
        logic signed [15:0] rx0;
        logic signed [23:0] rx1;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_done", longint'(done0), 0, 0);
        check("rst_busy", longint'(busy0), 0, 0);
        check("rst_cos", longint'(cos0), 0, 0);
        check("rst_sin", longint'(sin0), 0, 0);

        run0(16'sd804, "pi4", 1'b0);
        check("pi4_cos_abs", longint'(cos0), 724, 2);
        check("pi4_sin_abs", longint'(sin0), 724, 2);
        repeat (5) tick();
        check("hold_done", longint'(done0), 1, 0);
        check("hold_cos", longint'(cos0), 724, 2);

        run0(16'sd0, "zero", 1'b0);
        check("zero_cos_abs", longint'(cos0), 1024, 2);
        run0(16'sd1608, "hpi", 1'b0);
        check("hpi_sin_abs", longint'(sin0), 1024, 2);
        run0(-16'sd1608, "mhpi", 1'b0);
        check("mhpi_sin_abs", longint'(sin0), -1024, 2);

        run0(16'sd3217, "pi", 1'b0);
        if (RANGE) ec = -1024; else ec = 0;
        check("pi_cos_abs", longint'(cos0), ec, 2);
        run0(-16'sd2413, "m3pi4", 1'b0);
        if (RANGE) ec = -724; else ec = 0;
        check("m3pi4_cos_abs", longint'(cos0), ec, 2);

        // start while busy must be ignored; immediate restart from DONE follows
        run0(16'sd500, "ignore", 1'b1);
        run0(-16'sd300, "b2b", 1'b0);

        // reset in the middle of the iterations
        X0 = 16'sd700;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_done", longint'(done0), 0, 0);
        check("midrst_busy", longint'(busy0), 0, 0);
        check("midrst_cos", longint'(cos0), 0, 0);
        check("midrst_sin", longint'(sin0), 0, 0);
        repeat (20) tick();
        check("midrst_no_partial", longint'(done0), 0, 0);
        run0(16'sd700, "post_rst", 1'b0);

        for (int n = 0; n < 16; n++) begin
            rx0 = 16'($urandom_range(0, 8000)) - 16'sd4000;
            run0(rx0, "rnd16", 1'b0);
        end

        for (int n = 0; n < 64; n++) begin
            rx1 = 24'($urandom_range(0, 7000000)) - 24'sd3500000;
            run1(rx1, "rnd24");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
